// File: rtl/cla_pkg.sv
// Shared constants, stage payload fields and configuration check for the pipelined CLA adder.
package cla_pkg;

   localparam int unsigned GROUP = 4;

   // Width-independent part of a stage payload. Data vectors are added in the top, which knows WIDTH.
   typedef struct packed {
      logic valid;
      logic carry;
      logic msb_cin;
   } stage_ctrl_t;

   function automatic bit cfg_ok(input int unsigned width, input int unsigned block);
      return (block != 0) && (block % GROUP == 0) && (width % block == 0);
   endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle between the producer, the adder and the result consumer.
interface pipelined_cla_adder_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             overflow;

   modport master (
      output in_valid, a, b, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow
   );

   modport slave (
      input  in_valid, a, b, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow
   );
endinterface

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice built from 4-bit generate/propagate groups.
module cla_block import cla_pkg::*; #(
   parameter int unsigned BLOCK = 8
) (
   input  logic [BLOCK-1:0] a,
   input  logic [BLOCK-1:0] b,
   input  logic             cin,
   output logic [BLOCK-1:0] sum,
   output logic             cout,
   output logic             msb_cin
);
   localparam int unsigned NGRP = BLOCK / GROUP;

   logic [BLOCK-1:0] g;
   logic [BLOCK-1:0] p;
   logic [BLOCK-1:0] c;
   logic [NGRP-1:0]  gg;
   logic [NGRP-1:0]  gp;
   logic [NGRP:0]    gc;

   assign g = a & b;
   assign p = a ^ b;

   always_comb begin
      gg = '0;
      gp = '0;
      for (int j = 0; j < int'(NGRP); j++) begin
         gg[j] = g[j*4+3] | (p[j*4+3] & g[j*4+2]) | (p[j*4+3] & p[j*4+2] & g[j*4+1])
               | (p[j*4+3] & p[j*4+2] & p[j*4+1] & g[j*4]);
         gp[j] = &p[j*4 +: 4];
      end
   end

   // Group carries as flat sum-of-products over all lower groups and cin.
   always_comb begin
      logic acc;
      logic pp;
      gc    = '0;
      gc[0] = cin;
      for (int j = 0; j < int'(NGRP); j++) begin
         acc = gg[j];
         pp  = gp[j];
         for (int m = j - 1; m >= 0; m--) begin
            acc = acc | (pp & gg[m]);
            pp  = pp & gp[m];
         end
         gc[j+1] = acc | (pp & cin);
      end
   end

   always_comb begin
      c = '0;
      for (int j = 0; j < int'(NGRP); j++) begin
         c[j*4]   = gc[j];
         c[j*4+1] = g[j*4] | (p[j*4] & gc[j]);
         c[j*4+2] = g[j*4+1] | (p[j*4+1] & g[j*4]) | (p[j*4+1] & p[j*4] & gc[j]);
         c[j*4+3] = g[j*4+2] | (p[j*4+2] & g[j*4+1]) | (p[j*4+2] & p[j*4+1] & g[j*4])
                  | (p[j*4+2] & p[j*4+1] & p[j*4] & gc[j]);
      end
   end

   assign sum     = p ^ c;
   assign cout    = gc[NGRP];
   assign msb_cin = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined adder/subtractor: one BLOCK-bit CLA slice per stage, carry registered between stages,
// valid/ready handshake with full backpressure and bubble collapsing.
module pipelined_cla_adder import cla_pkg::*; #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned BLOCK = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   pipelined_cla_adder_if.slave bus
);
   localparam int unsigned STAGES = WIDTH / BLOCK;

   if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
      $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK a multiple of 4");
   end

   typedef struct packed {
      stage_ctrl_t      ctrl;
      logic [WIDTH-1:0] psum;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } stage_t;

   stage_t [STAGES-1:0] stage_q;
   logic   [STAGES-1:0] vld;
   logic   [STAGES-1:0] load;

   // A stage may load if it or any stage downstream of it is empty, or the consumer takes a beat.
   always_comb begin
      load = '0;
      for (int k = 0; k < int'(STAGES); k++) begin
         load[k] = bus.out_ready;
         for (int m = k; m < int'(STAGES); m++) begin
            if (!vld[m]) load[k] = 1'b1;
         end
      end
   end

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_stage
      logic             src_valid;
      logic             src_cin;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_psum;
      logic [BLOCK-1:0] blk_sum;
      logic             blk_cout;
      logic             blk_msb_cin;
      stage_t           st_d;
      stage_t           st_q;

      if (k == 0) begin : g_head
         assign src_valid = bus.in_valid;
         assign src_cin   = bus.sub;
         assign src_a     = bus.a;
         assign src_b     = bus.sub ? ~bus.b : bus.b;
         assign src_psum  = '0;
      end else begin : g_body
         assign src_valid = stage_q[k-1].ctrl.valid;
         assign src_cin   = stage_q[k-1].ctrl.carry;
         assign src_a     = stage_q[k-1].a;
         assign src_b     = stage_q[k-1].b;
         assign src_psum  = stage_q[k-1].psum;
      end

      cla_block #(
         .BLOCK (BLOCK)
      ) u_blk (
         .a       (src_a[k*BLOCK +: BLOCK]),
         .b       (src_b[k*BLOCK +: BLOCK]),
         .cin     (src_cin),
         .sum     (blk_sum),
         .cout    (blk_cout),
         .msb_cin (blk_msb_cin)
      );

      // Payload only changes when a real beat arrives, so a held result stays stable.
      always_comb begin
         st_d = st_q;
         if (load[k]) begin
            st_d.ctrl.valid = src_valid;
            if (src_valid) begin
               st_d.psum                   = src_psum;
               st_d.psum[k*BLOCK +: BLOCK] = blk_sum;
               st_d.ctrl.carry             = blk_cout;
               st_d.ctrl.msb_cin           = (k == int'(STAGES) - 1) ? blk_msb_cin : 1'b0;
               st_d.a                      = src_a;
               st_d.b                      = src_b;
            end
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            st_q <= '0;
         end else begin
            st_q <= st_d;
         end
      end

      assign stage_q[k] = st_q;
      assign vld[k]     = st_q.ctrl.valid;
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = stage_q[STAGES-1].ctrl.valid;
   assign bus.sum       = stage_q[STAGES-1].psum;
   assign bus.cout      = stage_q[STAGES-1].ctrl.carry;
   assign bus.overflow  = stage_q[STAGES-1].ctrl.msb_cin ^ stage_q[STAGES-1].ctrl.carry;

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
Parametrised, pipelined carry-lookahead adder/subtractor. It is the sequential successor to the 32-bit combinational carry-lookahead adder.
- Operands are split into BLOCK-bit slices. One slice is resolved per pipeline stage, and the carry is registered between stages.
- Valid/ready handshake on both sides with full backpressure.
- Sits between operand-producing datapath logic and a result consumer that may stall.

Parameters:
- WIDTH, 32: operand/result width in bits. Must be a multiple of BLOCK.
- BLOCK, 8: bits resolved per stage. Must be a multiple of 4, since 4-bit lookahead groups are used inside a stage.
- STAGES, WIDTH/BLOCK: derived, not overridable. Pipeline depth and latency in cycles.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  adder accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0 = a+b, 1 = a-b
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0. out_valid = 0, sum = 0, cout = 0, overflow = 0. in_ready = 1 once reset is released.
- Input transform: b_eff = sub ? ~b : b; cin = sub. Transform is applied at stage 0 capture.
- Stage k (k = 0..STAGES-1):
  - Computes bits [k*BLOCK +: BLOCK] with a BLOCK-bit CLA, using the carry registered by stage k-1 (stage 0 uses cin).
  - Registers: the partial sum so far, the carry out, the still-unprocessed upper slices of a and b_eff, and the carry into the MSB (last stage only).
- Outputs:
  - cout = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES-1, i.e. STAGES register stages. With no stalls, throughput is one beat per cycle.
- Handshake:
  - Transfer on the input side when in_valid & in_ready; on the output side when out_valid & out_ready.
  - Stage k may load when (stage k empty) OR (stage k+1 loads this cycle). The last stage treats out_ready as its downstream load.
  - in_ready = stage 0 may load. This ready chain is combinational and is the only comb path from out_ready to in_ready.
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
  - A stalled stage holds all of its registers unchanged.
  - Once out_valid is asserted, sum/cout/overflow stay stable until the transfer completes.
- Capacity: STAGES beats in flight. With out_ready held low, exactly STAGES beats are accepted, then in_ready = 0.
- Simultaneous input and output transfer when full is allowed; occupancy stays STAGES.
- Ordering: results leave in acceptance order. sub is carried per beat, so mixed add/sub streams are legal.
- Wrap-around: sum is truncated to WIDTH bits, with no saturation.
- Reset mid-operation: all in-flight beats are discarded with no partial output. out_valid drops asynchronously.
- in_valid with in_ready = 0: a, b and sub are ignored. Holding them is the producer's duty.

Decomposition:
- Package cla_pkg:
  - Elaboration check function asserting WIDTH % BLOCK == 0 and BLOCK % 4 == 0.
  - Group-size constant GROUP = 4.
  - Stage-payload struct typedef: valid, partial sum, carry, remaining a/b, msb_cin.
- Sub-module cla_block: combinational BLOCK-bit carry-lookahead slice.
  - Inputs: a, b, cin.
  - Outputs: sum, cout, msb_cin.
  - Built from 4-bit generate/propagate groups with group-level lookahead.
  - Instantiated once per stage.

Test Plan:
- Defaults (WIDTH=32, BLOCK=8). Feed a=32'h00000001, b=32'h00000001, sub=0 at cycle 0 -> out_valid at cycle 4, sum=32'h00000002, cout=0, overflow=0.
- Carry ripple across all stages: a=32'hFFFFFFFF, b=32'h00000001, sub=0 -> sum=32'h00000000, cout=1, overflow=0. Also a=32'h7FFFFFFF, b=32'h00000001 -> sum=32'h80000000, cout=0, overflow=1.
- Subtract: a=5, b=7, sub=1 -> sum=32'hFFFFFFFE, cout=0, overflow=0. Also a=32'h80000000, b=1, sub=1 -> sum=32'h7FFFFFFF, cout=1, overflow=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=i*16) with out_ready=0 for 10 cycles ->
  - in_ready falls after exactly 4 accepts.
  - sum held stable.
  - After out_ready=1, all 8 results emerge in order with zero loss or duplication.
  - Scoreboard compares against a+b and a-b for random WIDTH=64, BLOCK=16 runs of 10k beats with random valid/ready toggling.
- Reset mid-stream: 3 beats in flight, pull rst_n low asynchronously between edges -> out_valid=0, sum=0 immediately. After release, no stale beat appears and the next accepted beat returns the correct result after 4 cycles.
